// File: rtl/cog_vid_pkg.sv
// Shared definitions for the cog video sequencer.
//   cfg_state_t  : configuration sequencer states (IDLE -> SCL -> VID -> IDLE)
//   VID_MODE_*   : bit range of the video mode field inside the mode word;
//                  a zero field means the generator is disabled.
package cog_vid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCL  = 2'd1,
        VID  = 2'd2
    } cfg_state_t;

    localparam int unsigned VID_MODE_LSB = 29;
    localparam int unsigned VID_MODE_MSB = 30;

endpackage

// File: rtl/cog_vid_fifo.sv
// Synchronous FIFO of {color, pixel} pairs for the cog video sequencer.
// Ports:
//   clk_cog, nres          : clock, synchronous active-low reset
//   push, wr_color/pixel   : write a pair at the tail (dropped when full,
//                            unless a pop happens in the same cycle)
//   pop                    : remove the head pair (ignored when empty)
//   flush                  : empty the FIFO; overrides push and pop
//   head_color/head_pixel  : pair at the head (valid when !empty)
//   level, full, empty     : occupancy status
module cog_vid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk_cog,
    input  logic          nres,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   wr_color,
    input  logic [31:0]   wr_pixel,
    output logic [31:0]   head_color,
    output logic [31:0]   head_pixel,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

    assign head_color = mem[rd_ptr][63:32];
    assign head_pixel = mem[rd_ptr][31:0];

    // When full, a simultaneous pop frees the head slot; the write lands in
    // that same slot after the head has been read out this cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk_cog) begin
        if (do_push) begin
            mem[wr_ptr] <= {wr_color, wr_pixel};
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!nres || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cog_vid_seq.sv
// Cog-side sequencer for the cog video generator (clk_cog domain).
// Ports:
//   clk_cog, nres                 : clock, synchronous active-low reset
//   cfg_req, cfg_vid, cfg_scl     : request to write scale then mode
//   cfg_busy                      : configuration sequence in progress
//   push, push_color, push_pixel  : enqueue a {color, pixel} pair
//   full, level                   : FIFO status (current pair not counted)
//   vid_ack                       : generator acknowledge; rising edge consumes
//   setvid, setscl, data          : registered strobes/data to the generator
//   pixel, color                  : current pair presented to the generator
//   underrun, clr_underrun        : sticky consume-without-data flag and clear
module cog_vid_seq
    import cog_vid_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk_cog,
    input  logic          nres,
    input  logic          cfg_req,
    input  logic [31:0]   cfg_vid,
    input  logic [19:0]   cfg_scl,
    output logic          cfg_busy,
    input  logic          push,
    input  logic [31:0]   push_color,
    input  logic [31:0]   push_pixel,
    output logic          full,
    output logic [AW:0]   level,
    input  logic          vid_ack,
    output logic          setvid,
    output logic          setscl,
    output logic [31:0]   data,
    output logic [31:0]   pixel,
    output logic [31:0]   color,
    output logic          underrun,
    input  logic          clr_underrun
);

    cfg_state_t  state;
    cfg_state_t  next_state;
    logic [31:0] shadow_vid;
    logic [19:0] shadow_scl;
    logic        setvid_d;
    logic        setscl_d;
    logic        busy_d;
    logic [31:0] data_d;

    logic        ack_q;
    logic        ack_rise;
    logic        ack_eff;
    logic        en_q;
    logic        cur_valid;
    logic        mode_on;
    logic        flush;
    logic        load;

    logic        fifo_empty;
    logic [31:0] head_color;
    logic [31:0] head_pixel;

    assign mode_on  = |shadow_vid[VID_MODE_MSB:VID_MODE_LSB];
    assign flush    = (state == VID) && !mode_on;
    assign ack_rise = vid_ack & ~ack_q;
    assign ack_eff  = ack_rise & en_q;
    assign load     = (!cur_valid || ack_eff) && !fifo_empty && !flush;

    cog_vid_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_cog    (clk_cog),
        .nres       (nres),
        .push       (push),
        .pop        (load),
        .flush      (flush),
        .wr_color   (push_color),
        .wr_pixel   (push_pixel),
        .head_color (head_color),
        .head_pixel (head_pixel),
        .level      (level),
        .full       (full),
        .empty      (fifo_empty)
    );

    // Strobes are decoded from next_state so they are registered yet line
    // up with the state they belong to. On IDLE->SCL the shadow is being
    // loaded on the same edge, so the scale comes straight from cfg_scl.
    always_comb begin
        next_state = state;
        setscl_d   = 1'b0;
        setvid_d   = 1'b0;
        busy_d     = 1'b0;
        data_d     = '0;
        case (state)
            IDLE:    if (cfg_req) next_state = SCL;
            SCL:     next_state = VID;
            VID:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        case (next_state)
            SCL: begin
                setscl_d = 1'b1;
                busy_d   = 1'b1;
                data_d   = {12'b0, cfg_scl};
            end
            VID: begin
                setvid_d = 1'b1;
                busy_d   = 1'b1;
                data_d   = shadow_vid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            state    <= IDLE;
            setscl   <= 1'b0;
            setvid   <= 1'b0;
            cfg_busy <= 1'b0;
            data     <= '0;
            en_q     <= 1'b0;
        end else begin
            state    <= next_state;
            setscl   <= setscl_d;
            setvid   <= setvid_d;
            cfg_busy <= busy_d;
            data     <= data_d;
            if (state == VID) begin
                en_q <= mode_on;
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (state == IDLE && cfg_req) begin
            shadow_vid <= cfg_vid;
            shadow_scl <= cfg_scl;
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            ack_q     <= 1'b0;
            cur_valid <= 1'b0;
            pixel     <= '0;
            color     <= '0;
            underrun  <= 1'b0;
        end else begin
            ack_q <= vid_ack;
            if (flush) begin
                cur_valid <= 1'b0;
            end else if (load) begin
                pixel     <= head_pixel;
                color     <= head_color;
                cur_valid <= 1'b1;
            end else if (ack_eff) begin
                // Generator re-latches the stale pair; only the flag drops.
                cur_valid <= 1'b0;
            end
            if (ack_eff && !cur_valid) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cog_vid_seq.sv
module tb_cog_vid_seq;

    logic        clk_cog = 1'b0;
    logic        nres = 1'b0;
    logic        cfg_req = 1'b0;
    logic [31:0] cfg_vid = '0;
    logic [19:0] cfg_scl = '0;
    logic        cfg_busy;
    logic        push = 1'b0;
    logic [31:0] push_color = '0;
    logic [31:0] push_pixel = '0;
    logic        full;
    logic [2:0]  level;
    logic        vid_ack = 1'b0;
    logic        setvid;
    logic        setscl;
    logic [31:0] data;
    logic [31:0] pixel;
    logic [31:0] color;
    logic        underrun;
    logic        clr_underrun = 1'b0;

    int checks = 0;
    int errors = 0;

    cog_vid_seq #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk_cog      (clk_cog),
        .nres         (nres),
        .cfg_req      (cfg_req),
        .cfg_vid      (cfg_vid),
        .cfg_scl      (cfg_scl),
        .cfg_busy     (cfg_busy),
        .push         (push),
        .push_color   (push_color),
        .push_pixel   (push_pixel),
        .full         (full),
        .level        (level),
        .vid_ack      (vid_ack),
        .setvid       (setvid),
        .setscl       (setscl),
        .data         (data),
        .pixel        (pixel),
        .color        (color),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk_cog = ~clk_cog;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic set_push(input logic en, input logic [31:0] c, input logic [31:0] p);
        push       = en;
        push_color = c;
        push_pixel = p;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        nres = 1'b0;
        tick(); tick();
        nres = 1'b1;
        chk("rst_setvid", 32'(setvid), 32'd0);
        chk("rst_setscl", 32'(setscl), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_pixel", pixel, 32'd0);
        chk("rst_color", color, 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_level", 32'(level), 32'd0);

        // config sequence; second cfg_req lands in SCL and must be ignored
        cfg_req = 1'b1; cfg_scl = 20'h0A140; cfg_vid = 32'h2000_00FF;
        tick();
        cfg_scl = 20'h11111; cfg_vid = 32'h0;
        chk("cfg_scl_strobe", 32'(setscl), 32'd1);
        chk("cfg_scl_vidlow", 32'(setvid), 32'd0);
        chk("cfg_scl_data", data, 32'h0000_A140);
        chk("cfg_busy1", 32'(cfg_busy), 32'd1);
        tick();
        cfg_req = 1'b0;
        chk("cfg_vid_strobe", 32'(setvid), 32'd1);
        chk("cfg_vid_scllow", 32'(setscl), 32'd0);
        chk("cfg_vid_data", data, 32'h2000_00FF);
        chk("cfg_busy2", 32'(cfg_busy), 32'd1);
        tick();
        chk("cfg_done_busy", 32'(cfg_busy), 32'd0);
        chk("cfg_done_setvid", 32'(setvid), 32'd0);
        chk("cfg_done_data", data, 32'd0);
        tick();
        chk("cfg_no_restart", 32'(cfg_busy), 32'd0);

        // push A then B, ack held 3 cycles
        set_push(1'b1, 32'h0203_0405, 32'h1234_5678);
        tick();
        chk("pushA_level", 32'(level), 32'd1);
        chk("pushA_pixel_notyet", pixel, 32'd0);
        set_push(1'b1, 32'hA0B0_C0D0, 32'h8765_4321);
        tick();
        set_push(1'b0, '0, '0);
        chk("A_pixel", pixel, 32'h1234_5678);
        chk("A_color", color, 32'h0203_0405);
        chk("B_level1", 32'(level), 32'd1);
        vid_ack = 1'b1;
        tick();
        chk("B_pixel", pixel, 32'h8765_4321);
        chk("B_color", color, 32'hA0B0_C0D0);
        chk("B_level0", 32'(level), 32'd0);
        tick(); tick();
        vid_ack = 1'b0;
        chk("held_ack_pixel", pixel, 32'h8765_4321);
        chk("held_ack_underrun", 32'(underrun), 32'd0);
        tick();

        // empty FIFO: first ack drops cur_valid, second raises underrun
        vid_ack = 1'b1; tick(); vid_ack = 1'b0;
        chk("ack1_underrun", 32'(underrun), 32'd0);
        chk("ack1_stale_pixel", pixel, 32'h8765_4321);
        tick();
        vid_ack = 1'b1; tick(); vid_ack = 1'b0;
        chk("ack2_underrun", 32'(underrun), 32'd1);
        tick();
        chk("underrun_sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
        chk("underrun_clr", 32'(underrun), 32'd0);

        // six pushes, no ack: 1 current + 4 queued, sixth dropped
        for (int i = 1; i <= 6; i++) begin
            set_push(1'b1, 32'hC000_0000 + 32'(i), 32'h1000_0000 + 32'(i));
            tick();
            if (i == 4) chk("fill4_full", 32'(full), 32'd0);
            if (i == 5) chk("fill5_full", 32'(full), 32'd1);
        end
        set_push(1'b0, '0, '0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_pixel", pixel, 32'h1000_0001);

        // push coincident with ack while full
        set_push(1'b1, 32'hC000_0007, 32'h1000_0007);
        vid_ack = 1'b1;
        tick();
        set_push(1'b0, '0, '0);
        vid_ack = 1'b0;
        chk("popush_level", 32'(level), 32'd4);
        chk("popush_full", 32'(full), 32'd1);
        chk("popush_pixel", pixel, 32'h1000_0002);
        tick();
        begin
            logic [31:0] exp_q [4];
            exp_q[0] = 32'h1000_0003; exp_q[1] = 32'h1000_0004;
            exp_q[2] = 32'h1000_0005; exp_q[3] = 32'h1000_0007;
            for (int i = 0; i < 4; i++) begin
                vid_ack = 1'b1; tick(); vid_ack = 1'b0;
                chk("drain_pixel", pixel, exp_q[i]);
                chk("drain_color", color, exp_q[i] + 32'hB000_0000);
                chk("drain_level", 32'(level), 32'(3 - i));
                tick();
            end
        end

        // flush via mode 0 with three queued
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'hD000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
            tick();
        end
        set_push(1'b0, '0, '0);
        chk("preflush_level", 32'(level), 32'd3);
        cfg_req = 1'b1; cfg_scl = 20'h01005; cfg_vid = 32'h0;
        tick();
        cfg_req = 1'b0;
        chk("flush_scl_data", data, 32'h0000_1005);
        tick();
        chk("flush_vid_strobe", 32'(setvid), 32'd1);
        chk("flush_vid_data", data, 32'd0);
        chk("flush_level_before", 32'(level), 32'd3);
        tick();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_busy", 32'(cfg_busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            vid_ack = 1'b1; tick(); vid_ack = 1'b0; tick();
        end
        chk("disabled_ack_underrun", 32'(underrun), 32'd0);
        chk("disabled_ack_pixel", pixel, 32'h1000_0007);
        // cur_valid was cleared, so a new pair loads straight through
        set_push(1'b1, 32'hE000_0001, 32'h3000_0001);
        tick();
        set_push(1'b0, '0, '0);
        vid_ack = 1'b1;
        tick();
        vid_ack = 1'b0;
        chk("postflush_pixel", pixel, 32'h3000_0001);
        chk("postflush_level", 32'(level), 32'd0);
        chk("postflush_underrun", 32'(underrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
